// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: opcode constants, NOP encoding, XLEN and fetch-state enum.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_RT  = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/opcode_check.sv
// Combinational compare of a 7-bit opcode against the supported instruction set.
module opcode_check
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal
);

  assign o_legal = (i_opcode == OP_RT) || (i_opcode == OP_LW) ||
                   (i_opcode == OP_SW) || (i_opcode == OP_BEQ);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/ISSUE/DRAIN handshake between instruction memory and decode.
// Optional illegal-opcode filtering is enabled with macro IFETCH_ILLEGAL_CHECK_EN.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            illegal
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_instr;
  logic            r_req;
  logic            r_valid;
  logic            r_illegal;

  logic            w_ack;
  logic            w_hs;
  logic            w_illegal;
  logic [XLEN-1:0] w_flush_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_issue_pc;

  // An ack only counts while our own request is outstanding.
  assign w_ack      = r_req & imem_ack;
  assign w_hs       = r_valid & instr_ready;
  assign w_flush_pc = word_align(flush_pc);
  assign w_pc_next  = branch_taken ? word_align(branch_target) : (r_pc + 32'd4);
  assign w_issue_pc = flush ? w_flush_pc : w_pc_next;

`ifdef IFETCH_ILLEGAL_CHECK_EN
  logic w_legal;

  opcode_check u_opcode_check (
    .i_opcode (imem_rdata[6:0]),
    .o_legal  (w_legal)
  );

  assign w_illegal = ~w_legal;
  assign instr     = r_illegal ? NOP : r_instr;
`else
  assign w_illegal = 1'b0;
  assign instr     = r_instr;
`endif

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = r_valid;
  assign opcode      = r_instr[6:0];
  assign pc          = r_pc;
  assign illegal     = r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_pc      <= word_align(RESET_PC);
      r_addr    <= word_align(RESET_PC);
      r_instr   <= NOP;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          r_req <= 1'b1;
          if (flush) begin
            r_pc <= w_flush_pc;
            // An unanswered request must be drained at its original address.
            if (r_req && !imem_ack) r_state <= DRAIN;
            else                    r_addr  <= w_flush_pc;
          end else if (w_ack) begin
            r_state   <= ISSUE;
            r_req     <= 1'b0;
            r_valid   <= 1'b1;
            r_instr   <= imem_rdata;
            r_illegal <= w_illegal;
          end
        end
        ISSUE: begin
          if (flush || w_hs) begin
            r_state   <= FETCH;
            r_req     <= 1'b1;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_pc      <= w_issue_pc;
            r_addr    <= w_issue_pc;
          end
        end
        DRAIN: begin
          if (flush) r_pc <= w_flush_pc;
          if (w_ack) begin
            r_state <= FETCH;
            r_addr  <= flush ? w_flush_pc : r_pc;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
